// File: rtl/ysyx_25040111_pkg.sv
// Shared encodings, payload types and helpers for the LSU AXI master.
package ysyx_25040111_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned ID_W   = 4;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;

    localparam logic [2:0] SIZE_B = 3'b000;
    localparam logic [2:0] SIZE_H = 3'b001;
    localparam logic [2:0] SIZE_W = 3'b010;

    localparam logic [1:0] MASK_B = 2'b00;
    localparam logic [1:0] MASK_H = 2'b01;
    localparam logic [1:0] MASK_W = 2'b10;

    typedef enum logic [2:0] {
        LSU_IDLE = 3'd0,
        LSU_AR   = 3'd1,
        LSU_R    = 3'd2,
        LSU_WR   = 3'd3,
        LSU_B    = 3'd4
    } lsu_state_t;

    // Address-channel payload shared by AR and AW
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } axi_ax_t;

    // Access width code -> AXI size (10 and 11 both mean a full word)
    function automatic logic [2:0] mask_to_size(input logic [1:0] mask);
        logic [2:0] size;
        case (mask)
            MASK_B:  size = SIZE_B;
            MASK_H:  size = SIZE_H;
            default: size = SIZE_W;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/ysyx_25040111_lsu_align.sv
// Combinational load extraction and store lane shifting / strobe generation.
module ysyx_25040111_lsu_align
    import ysyx_25040111_pkg::*;
(
    input  logic [1:0]        raddr_lo,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rmask,
    input  logic              rsign,
    input  logic              burst,
    output logic [DATA_W-1:0] load_data,
    input  logic [1:0]        waddr_lo,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        wmask,
    output logic [DATA_W-1:0] store_data,
    output logic [STRB_W-1:0] store_strb
);

    logic [DATA_W-1:0] shifted;
    logic [STRB_W-1:0] strb_base;

    // Load: bursts return raw words; singles are lane-shifted then extended
    always_comb begin
        shifted   = rdata >> {raddr_lo, 3'b000};
        load_data = shifted;
        if (burst) begin
            load_data = rdata;
        end else begin
            case (rmask)
                MASK_B:  load_data = {{24{rsign & shifted[7]}}, shifted[7:0]};
                MASK_H:  load_data = {{16{rsign & shifted[15]}}, shifted[15:0]};
                default: load_data = shifted;
            endcase
        end
    end

    // Store: move data and strobes onto the addressed byte lanes
    always_comb begin
        case (wmask)
            MASK_B:  strb_base = 4'b0001;
            MASK_H:  strb_base = 4'b0011;
            default: strb_base = 4'b1111;
        endcase
        store_strb = strb_base << waddr_lo;
        store_data = wdata << {waddr_lo, 3'b000};
    end

endmodule

// File: rtl/ysyx_25040111_lsu.sv
// LSU: turns arbiter load/store/refill requests into single AXI4 transactions.
module ysyx_25040111_lsu
    import ysyx_25040111_pkg::*;
#(
    parameter logic [ID_W-1:0]  AXI_ID  = 4'd1,
    parameter logic [LEN_W-1:0] MAX_LEN = 8'd7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lsu_rvalid,
    output logic              lsu_rready,
    output logic [DATA_W-1:0] lsu_rdata,
    input  logic [ADDR_W-1:0] lsu_raddr,
    input  logic [LEN_W-1:0]  lsu_rlen,
    input  logic              lsu_burst,
    input  logic              lsu_rsign,
    input  logic [1:0]        lsu_rmask,
    input  logic              lsu_wvalid,
    output logic              lsu_wready,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [ADDR_W-1:0] lsu_waddr,
    input  logic [1:0]        lsu_wmask,
    output logic              lsu_err,
    output logic              io_master_arvalid,
    input  logic              io_master_arready,
    output logic [ADDR_W-1:0] io_master_araddr,
    output logic [ID_W-1:0]   io_master_arid,
    output logic [LEN_W-1:0]  io_master_arlen,
    output logic [2:0]        io_master_arsize,
    output logic [1:0]        io_master_arburst,
    input  logic              io_master_rvalid,
    output logic              io_master_rready,
    input  logic [DATA_W-1:0] io_master_rdata,
    input  logic [1:0]        io_master_rresp,
    input  logic              io_master_rlast,
    input  logic [ID_W-1:0]   io_master_rid,
    output logic              io_master_awvalid,
    input  logic              io_master_awready,
    output logic [ADDR_W-1:0] io_master_awaddr,
    output logic [ID_W-1:0]   io_master_awid,
    output logic [LEN_W-1:0]  io_master_awlen,
    output logic [2:0]        io_master_awsize,
    output logic [1:0]        io_master_awburst,
    output logic              io_master_wvalid,
    input  logic              io_master_wready,
    output logic [DATA_W-1:0] io_master_wdata,
    output logic [STRB_W-1:0] io_master_wstrb,
    output logic              io_master_wlast,
    input  logic              io_master_bvalid,
    output logic              io_master_bready,
    input  logic [1:0]        io_master_bresp,
    input  logic [ID_W-1:0]   io_master_bid
);

    lsu_state_t        state_q, state_d;
    axi_ax_t           ar_q, aw_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [1:0]        rd_mask_q;
    logic              rd_sign_q, rd_burst_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              aw_done_q, w_done_q;
    logic [LEN_W-1:0]  rlen_clamped;
    logic [DATA_W-1:0] load_data, store_data;
    logic [STRB_W-1:0] store_strb;
    logic              unused_bits;

    // Response IDs and the low resp bit carry no information for this master
    assign unused_bits = ^{io_master_rid, io_master_bid, io_master_rresp[0], io_master_bresp[0]};

    assign rlen_clamped = (lsu_rlen > MAX_LEN) ? MAX_LEN : lsu_rlen;

    assign io_master_arid    = AXI_ID;
    assign io_master_araddr  = ar_q.addr;
    assign io_master_arlen   = ar_q.len;
    assign io_master_arsize  = ar_q.size;
    assign io_master_arburst = ar_q.burst;
    assign io_master_awid    = AXI_ID;
    assign io_master_awaddr  = aw_q.addr;
    assign io_master_awlen   = aw_q.len;
    assign io_master_awsize  = aw_q.size;
    assign io_master_awburst = aw_q.burst;
    assign io_master_wdata   = wdata_q;
    assign io_master_wstrb   = wstrb_q;
    assign io_master_wlast   = 1'b1;

    ysyx_25040111_lsu_align u_align (
        .raddr_lo   (ar_q.addr[1:0]),
        .rdata      (io_master_rdata),
        .rmask      (rd_mask_q),
        .rsign      (rd_sign_q),
        .burst      (rd_burst_q),
        .load_data  (load_data),
        .waddr_lo   (lsu_waddr[1:0]),
        .wdata      (lsu_wdata),
        .wmask      (lsu_wmask),
        .store_data (store_data),
        .store_strb (store_strb)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; read wins when both requests arrive
    always_comb begin
        state_d           = state_q;
        io_master_arvalid = 1'b0;
        io_master_rready  = 1'b0;
        io_master_awvalid = 1'b0;
        io_master_wvalid  = 1'b0;
        io_master_bready  = 1'b0;
        lsu_rready        = 1'b0;
        lsu_rdata         = '0;
        lsu_wready        = 1'b0;
        lsu_err           = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (lsu_rvalid) begin
                    state_d = LSU_AR;
                end else if (lsu_wvalid) begin
                    state_d = LSU_WR;
                end
            end
            LSU_AR: begin
                io_master_arvalid = 1'b1;
                if (io_master_arready) begin
                    state_d = LSU_R;
                end
            end
            LSU_R: begin
                io_master_rready = 1'b1;
                if (io_master_rvalid) begin
                    lsu_rready = 1'b1;
                    lsu_rdata  = load_data;
                    lsu_err    = io_master_rresp[1];
                    if (io_master_rlast || (cnt_q == '0)) begin
                        state_d = LSU_IDLE;
                    end
                end
            end
            LSU_WR: begin
                io_master_awvalid = ~aw_done_q;
                io_master_wvalid  = ~w_done_q;
                if ((aw_done_q || io_master_awready) && (w_done_q || io_master_wready)) begin
                    state_d = LSU_B;
                end
            end
            LSU_B: begin
                io_master_bready = 1'b1;
                if (io_master_bvalid) begin
                    lsu_wready = 1'b1;
                    lsu_err    = io_master_bresp[1];
                    state_d    = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // Request capture, beat counter and AW/W completion flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ar_q       <= '0;
            aw_q       <= '0;
            cnt_q      <= '0;
            rd_mask_q  <= '0;
            rd_sign_q  <= 1'b0;
            rd_burst_q <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (lsu_rvalid) begin
                        ar_q <= '{addr:  lsu_raddr,
                                  len:   lsu_burst ? rlen_clamped : '0,
                                  size:  lsu_burst ? SIZE_W : mask_to_size(lsu_rmask),
                                  burst: lsu_burst ? AXI_BURST_INCR : AXI_BURST_FIXED};
                        cnt_q      <= lsu_burst ? rlen_clamped : '0;
                        rd_mask_q  <= lsu_rmask;
                        rd_sign_q  <= lsu_rsign;
                        rd_burst_q <= lsu_burst;
                    end else if (lsu_wvalid) begin
                        aw_q <= '{addr:  lsu_waddr,
                                  len:   '0,
                                  size:  mask_to_size(lsu_wmask),
                                  burst: AXI_BURST_FIXED};
                        wdata_q   <= store_data;
                        wstrb_q   <= store_strb;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                LSU_R: begin
                    if (io_master_rvalid && (cnt_q != '0)) begin
                        cnt_q <= cnt_q - LEN_W'(1);
                    end
                end
                LSU_WR: begin
                    if (io_master_awvalid && io_master_awready) begin
                        aw_done_q <= 1'b1;
                    end
                    if (io_master_wvalid && io_master_wready) begin
                        w_done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_lsu.sv
// Bench: procedural AXI slave plus arithmetic reference model for the LSU.
module tb_ysyx_25040111_lsu;

    logic        clock = 1'b0;
    logic        reset;
    logic        lsu_rvalid, lsu_rready, lsu_burst, lsu_rsign;
    logic [31:0] lsu_rdata, lsu_raddr;
    logic [7:0]  lsu_rlen;
    logic [1:0]  lsu_rmask;
    logic        lsu_wvalid, lsu_wready, lsu_err;
    logic [31:0] lsu_wdata, lsu_waddr;
    logic [1:0]  lsu_wmask;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] araddr, rdata;
    logic [3:0]  arid, rid, awid, bid;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0] awaddr, wdata;
    logic [3:0]  wstrb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    ysyx_25040111_lsu dut (
        .clock(clock), .reset(reset),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata),
        .lsu_raddr(lsu_raddr), .lsu_rlen(lsu_rlen), .lsu_burst(lsu_burst),
        .lsu_rsign(lsu_rsign), .lsu_rmask(lsu_rmask),
        .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_wdata(lsu_wdata),
        .lsu_waddr(lsu_waddr), .lsu_wmask(lsu_wmask), .lsu_err(lsu_err),
        .io_master_arvalid(arvalid), .io_master_arready(arready), .io_master_araddr(araddr),
        .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize),
        .io_master_arburst(arburst),
        .io_master_rvalid(rvalid), .io_master_rready(rready), .io_master_rdata(rdata),
        .io_master_rresp(rresp), .io_master_rlast(rlast), .io_master_rid(rid),
        .io_master_awvalid(awvalid), .io_master_awready(awready), .io_master_awaddr(awaddr),
        .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize),
        .io_master_awburst(awburst),
        .io_master_wvalid(wvalid), .io_master_wready(wready), .io_master_wdata(wdata),
        .io_master_wstrb(wstrb), .io_master_wlast(wlast),
        .io_master_bvalid(bvalid), .io_master_bready(bready), .io_master_bresp(bresp),
        .io_master_bid(bid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: AXI size from access width
    function automatic logic [31:0] exp_size(input logic burst, input logic [1:0] mask);
        if (burst || mask >= 2'd2) return 32'd2;
        return (mask == 2'd1) ? 32'd1 : 32'd0;
    endfunction

    // Reference model: value a load returns for a given bus word
    function automatic logic [31:0] exp_load(input logic [31:0] word, input int off,
                                             input logic [1:0] mask, input logic sign);
        logic [31:0] v;
        v = word >> (8 * off);
        if (mask == 2'd0) begin
            v = v % 32'd256;
            if (sign && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (mask == 2'd1) begin
            v = v % 32'd65536;
            if (sign && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_strb(input int off, input logic [1:0] mask);
        int bytes;
        bytes = (mask == 2'd0) ? 1 : (mask == 2'd1) ? 2 : 4;
        return 32'((((1 << bytes) - 1) << off) % 16);
    endfunction

    // Single or burst read; abort_at >= 0 asserts reset when that beat is on the bus
    task automatic read_txn(input logic [31:0] addr, input logic [7:0] len, input logic burst,
                            input logic [1:0] mask, input logic sign, input bit use_fix,
                            input logic [31:0] fix_word, input bit gaps, input bit no_rlast,
                            input bit err_last, input bit wpend, input int abort_at);
        int n, d;
        logic [31:0] word;
        n = burst ? ((len > 8'd7) ? 8 : int'(len) + 1) : 1;
        @(negedge clock);
        lsu_rvalid = 1'b1; lsu_raddr = addr; lsu_rlen = len; lsu_burst = burst;
        lsu_rmask = mask; lsu_rsign = sign;
        if (wpend) lsu_wvalid = 1'b1;
        @(negedge clock); #1;
        check("ar_latency", 32'(arvalid), 32'd1);
        if (!arvalid) begin
            lsu_rvalid = 1'b0;
            return;
        end
        check("araddr", araddr, addr);
        check("arlen", 32'(arlen), burst ? ((len > 8'd7) ? 32'd7 : 32'(len)) : 32'd0);
        check("arsize", 32'(arsize), exp_size(burst, mask));
        check("arburst", 32'(arburst), burst ? 32'd1 : 32'd0);
        check("arid", 32'(arid), 32'd1);
        check("aw_blocked", 32'(awvalid), 32'd0);
        d = gaps ? $urandom_range(0, 2) : 0;
        for (int k = 0; k < d; k++) begin
            @(negedge clock); #1;
            check("ar_hold", 32'(arvalid), 32'd1);
        end
        arready = 1'b1;
        @(negedge clock);
        arready = 1'b0;
        for (int i = 0; i < n; i++) begin
            d = gaps ? $urandom_range(0, 2) : 0;
            for (int k = 0; k < d; k++) begin
                #1;
                check("r_gap_rready", 32'(rready), 32'd1);
                check("r_gap_pulse", 32'(lsu_rready), 32'd0);
                @(negedge clock);
            end
            word   = use_fix ? fix_word : $urandom;
            rvalid = 1'b1; rdata = word;
            rlast  = (i == n - 1) && !no_rlast;
            rresp  = (err_last && i == n - 1) ? 2'b10 : 2'b00;
            #1;
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                check("rst_lsu_rready", 32'(lsu_rready), 32'd0);
                check("rst_rready", 32'(rready), 32'd0);
                check("rst_arvalid", 32'(arvalid), 32'd0);
                check("rst_araddr", araddr, 32'd0);
                lsu_rvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0;
                @(negedge clock);
                reset = 1'b0;
                return;
            end
            check("r_pulse", 32'(lsu_rready), 32'd1);
            check("r_data", lsu_rdata, burst ? word : exp_load(word, int'(addr[1:0]), mask, sign));
            check("r_err", 32'(lsu_err), (err_last && i == n - 1) ? 32'd1 : 32'd0);
            @(negedge clock);
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        end
        // Beat offered after completion must not be taken
        lsu_rvalid = 1'b0;
        rvalid = 1'b1; rlast = 1'b1;
        #1;
        check("r_extra", 32'(lsu_rready), 32'd0);
        check("r_extra_rready", 32'(rready), 32'd0);
        @(negedge clock);
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] mask,
                             input logic [1:0] resp, input int aw_d, input int w_d, input int b_d);
        bit aw_got, w_got;
        int c, off;
        off = int'(addr[1:0]);
        @(negedge clock);
        lsu_wvalid = 1'b1; lsu_waddr = addr; lsu_wdata = data; lsu_wmask = mask;
        c = 0;
        do begin
            @(negedge clock); #1;
            c++;
        end while (!awvalid && c < 8);
        check("aw_start", 32'(awvalid), 32'd1);
        if (!awvalid) begin
            lsu_wvalid = 1'b0;
            return;
        end
        check("w_start", 32'(wvalid), 32'd1);
        check("awaddr", awaddr, addr);
        check("awlen", 32'(awlen), 32'd0);
        check("awsize", 32'(awsize), exp_size(1'b0, mask));
        check("awburst", 32'(awburst), 32'd0);
        check("awid", 32'(awid), 32'd1);
        check("wdata", wdata, data << (8 * off));
        check("wstrb", 32'(wstrb), exp_strb(off, mask));
        check("wlast", 32'(wlast), 32'd1);
        aw_got = 1'b0; w_got = 1'b0; c = 0;
        while (!(aw_got && w_got) && c < 20) begin
            awready = (c >= aw_d) && !aw_got;
            wready  = (c >= w_d) && !w_got;
            #1;
            check("awvalid_hold", 32'(awvalid), aw_got ? 32'd0 : 32'd1);
            check("wvalid_hold", 32'(wvalid), w_got ? 32'd0 : 32'd1);
            if (awready) aw_got = 1'b1;
            if (wready)  w_got  = 1'b1;
            c++;
            @(negedge clock);
        end
        awready = 1'b0; wready = 1'b0;
        for (int k = 0; k < b_d; k++) begin
            #1;
            check("b_wait_bready", 32'(bready), 32'd1);
            check("b_wait_pulse", 32'(lsu_wready), 32'd0);
            @(negedge clock);
        end
        bvalid = 1'b1; bresp = resp;
        #1;
        check("w_pulse", 32'(lsu_wready), 32'd1);
        check("w_err", 32'(lsu_err), 32'(resp[1]));
        @(negedge clock);
        bvalid = 1'b0; bresp = 2'b00; lsu_wvalid = 1'b0;
        #1;
        check("w_pulse_end", 32'(lsu_wready), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, dat;
        logic [1:0]  m;
        reset = 1'b1;
        lsu_rvalid = 0; lsu_raddr = 0; lsu_rlen = 0; lsu_burst = 0; lsu_rsign = 0; lsu_rmask = 0;
        lsu_wvalid = 0; lsu_wdata = 0; lsu_waddr = 0; lsu_wmask = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 4'd1;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 4'd1;
        repeat (3) @(negedge clock);
        #1;
        check("rst_arvalid0", 32'(arvalid), 32'd0);
        check("rst_awvalid0", 32'(awvalid), 32'd0);
        check("rst_wvalid0", 32'(wvalid), 32'd0);
        check("rst_rready0", 32'(rready), 32'd0);
        check("rst_bready0", 32'(bready), 32'd0);
        check("rst_pulses0", 32'({lsu_rready, lsu_wready, lsu_err}), 32'd0);
        check("rst_regs0", araddr | awaddr | wdata | 32'(wstrb) | 32'(arlen), 32'd0);
        reset = 1'b0;

        // lw, lb, lbu
        read_txn(32'h8000_0004, 8'd0, 1'b0, 2'b10, 1'b0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, -1);
        read_txn(32'h8000_0003, 8'd0, 1'b0, 2'b00, 1'b1, 1, 32'h80AA_BBCC, 0, 0, 0, 0, -1);
        read_txn(32'h8000_0003, 8'd0, 1'b0, 2'b00, 1'b0, 1, 32'h80AA_BBCC, 0, 0, 0, 0, -1);
        // sh with AW accepted two cycles after W
        write_txn(32'h8000_0002, 32'h0000_1234, 2'b01, 2'b00, 2, 0, 1);
        // INCR refill with gaps, clamped length, exit on count without rlast
        read_txn(32'h3000_0000, 8'd3, 1'b1, 2'b10, 1'b0, 0, 32'd0, 1, 0, 0, 0, -1);
        read_txn(32'h3000_0040, 8'd12, 1'b1, 2'b10, 1'b0, 0, 32'd0, 1, 1, 0, 0, -1);
        // simultaneous read and write: read first, write after
        lsu_waddr = 32'h8000_0101; lsu_wdata = 32'h0000_00A5; lsu_wmask = 2'b00;
        read_txn(32'h8000_0010, 8'd0, 1'b0, 2'b01, 1'b1, 0, 32'd0, 0, 0, 0, 1, -1);
        write_txn(32'h8000_0101, 32'h0000_00A5, 2'b00, 2'b00, 0, 1, 0);
        // reset in R with two beats left, then normal traffic and error responses
        read_txn(32'h3000_0000, 8'd3, 1'b1, 2'b10, 1'b0, 0, 32'd0, 0, 0, 0, 0, 2);
        read_txn(32'h8000_0008, 8'd0, 1'b0, 2'b10, 1'b0, 0, 32'd0, 0, 0, 0, 0, -1);
        write_txn(32'h8000_0000, 32'hCAFE_F00D, 2'b10, 2'b10, 0, 0, 0);
        read_txn(32'h8000_000C, 8'd0, 1'b0, 2'b10, 1'b0, 0, 32'd0, 0, 0, 1, 0, -1);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            a   = $urandom;
            dat = $urandom;
            m   = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: read_txn(a, 8'd0, 1'b0, m, 1'($urandom_range(0, 1)), 0, 32'd0, 1, 0,
                            1'($urandom_range(0, 1)), 0, -1);
                1: read_txn({a[31:2], 2'b00}, 8'($urandom_range(0, 10)), 1'b1, 2'b10, 1'b0, 0, 32'd0,
                            1, 1'($urandom_range(0, 1)), 0, 0, -1);
                default: write_txn(a, dat, m, 2'($urandom_range(0, 3)), $urandom_range(0, 3),
                                   $urandom_range(0, 3), $urandom_range(0, 2));
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
